// File: rtl/ram_burst_reader.sv
// ram_burst_reader: issues back-to-back RAM reads for a burst and streams the words out
// over valid/ready, using a read-credit limit so the small output FIFO can never overflow.
module ram_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE = 1024,
  parameter int LATENCY = 1,
  parameter int MAX_LEN = 256,
  parameter int FIFO_DEPTH = LATENCY + 2,
  localparam int AW = $clog2(SIZE),
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [AW-1:0]         req_addr,
  input  logic [LW-1:0]         req_len,
  output logic                  ram_en,
  output logic [AW-1:0]         ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_nx;
  logic [AW-1:0] cur;
  logic [LW-1:0] remaining, len_q, beat;
  logic [LATENCY-1:0] vld;
  logic [CW-1:0] inflight, count;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr, rd;
  logic accept, push, pop, credit;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign accept = req_valid && req_ready;
  // every read in flight already owns a FIFO slot
  assign credit = (CW+1)'(inflight) + (CW+1)'(count) < (CW+1)'(FIFO_DEPTH);
  assign ram_en = state == ISSUE && credit;
  assign ram_addr = cur;
  assign push = vld[LATENCY-1];
  assign out_valid = count != '0;
  assign pop = out_valid && out_ready;
  assign out_data = mem[rd];
  assign out_last = out_valid && beat == len_q;

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    if (state == IDLE && accept && req_len != '0) state_nx = ISSUE;
    if (state == ISSUE && ram_en && remaining == LW'(1)) state_nx = DRAIN;
    if (state == DRAIN && pop && out_last) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cur <= '0;
      remaining <= '0;
      len_q <= '0;
      beat <= '0;
      vld <= '0;
      inflight <= '0;
      count <= '0;
      wr <= '0;
      rd <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        cur <= req_addr;
        remaining <= req_len;
        len_q <= req_len;
        beat <= LW'(1);
      end
      if (ram_en) begin
        cur <= (cur == AW'(SIZE - 1)) ? '0 : cur + AW'(1);
        remaining <= remaining - LW'(1);
      end
      vld[0] <= ram_en;
      for (int i = 1; i < LATENCY; i++) vld[i] <= vld[i-1];
      inflight <= inflight + CW'(ram_en) - CW'(push);
      if (push) begin
        mem[wr] <= ram_rdata;
        wr <= inc(wr);
      end
      if (pop) begin
        rd <= inc(rd);
        beat <= beat + LW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader: drives a LATENCY=1 and a LATENCY=3 reader with the same bursts and
// checks addresses, beats, last flags, stalls, credit and first-beat latency against a burst model.
module tb_ram_burst_reader;
  localparam int SIZE = 1024, AW = 10, LW = 9;
  logic clk = 0, rst = 0, req_valid = 0, out_ready = 1;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic rr[2], en[2], ov[2], ol[2], bz[2], pl[2];
  logic [AW-1:0] ad[2];
  logic [31:0] rdat[2], od[2], pd[2];
  logic [31:0] s0, s1;
  int checks = 0, failures = 0, cyc = 0, hs = 0, mode = 0, pc = 0, base = 0, blen = 0;
  int issued[2], popped[2];
  bit seen[2], stall[2];

  always #5 clk = ~clk;

  ram_burst_reader #(.LATENCY(1)) d1 (.clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr[0]),
    .req_addr(req_addr), .req_len(req_len), .ram_en(en[0]), .ram_addr(ad[0]), .ram_rdata(rdat[0]),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_last(ol[0]), .busy(bz[0]));
  ram_burst_reader #(.LATENCY(3)) d3 (.clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr[1]),
    .req_addr(req_addr), .req_len(req_len), .ram_en(en[1]), .ram_addr(ad[1]), .ram_rdata(rdat[1]),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_last(ol[1]), .busy(bz[1]));

  // RAM preloaded with mem[i] = i + 0x100
  always @(posedge clk) begin
    if (en[0]) rdat[0] <= 32'(ad[0]) + 32'h100;
    if (en[1]) s0 <= 32'(ad[1]) + 32'h100;
    s1 <= s0;
    rdat[1] <= s1;
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom % 2) : 1'(pc % 3 == 0);
    pc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (rst) for (int k = 0; k < 2; k++) begin
    if (en[k]) begin
      chk("issue_in_burst", 32'(issued[k] < blen), 1);
      chk("ram_addr", 32'(ad[k]), 32'((base + issued[k]) % SIZE));
      chk("credit", 32'(issued[k] - popped[k] < (k ? 5 : 3)), 1);
      issued[k]++;
    end
    if (ov[k]) begin
      if (!seen[k]) begin
        chk(k ? "first_latency3" : "first_latency1", cyc - hs, k ? 4 : 2);
        seen[k] = 1;
      end
      if (stall[k]) begin
        chk("stall_data", od[k], pd[k]);
        chk("stall_last", 32'(ol[k]), 32'(pl[k]));
      end
      if (out_ready) begin
        chk("beat_in_burst", 32'(popped[k] < blen), 1);
        chk("beat_data", od[k], 32'((base + popped[k]) % SIZE + 256));
        chk("beat_last", 32'(ol[k]), 32'(popped[k] == blen - 1));
        popped[k]++;
      end
    end
    stall[k] = ov[k] && !out_ready;
    pd[k] = od[k];
    pl[k] = ol[k];
  end

  task automatic clear_model(input int a, input int l);
    base = a;
    blen = l;
    for (int k = 0; k < 2; k++) begin
      issued[k] = 0;
      popped[k] = 0;
      seen[k] = 0;
      stall[k] = 0;
    end
  endtask

  task automatic chk_reset();
    for (int k = 0; k < 2; k++) begin
      chk("rst_req_ready", 32'(rr[k]), 1);
      chk("rst_ram_en", 32'(en[k]), 0);
      chk("rst_ram_addr", 32'(ad[k]), 0);
      chk("rst_out_valid", 32'(ov[k]), 0);
      chk("rst_out_data", od[k], 0);
      chk("rst_out_last", 32'(ol[k]), 0);
      chk("rst_busy", 32'(bz[k]), 0);
    end
  endtask

  task automatic req(input int a, input int l);
    int t = 0;
    while (!(rr[0] && rr[1]) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("req_ready_wait", 32'(rr[0] && rr[1]), 1);
    clear_model(a, l);
    req_valid = 1;
    req_addr = AW'(a);
    req_len = LW'(l);
    @(posedge clk); #1;
    hs = cyc;
    req_valid = 0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((bz[0] || bz[1] || popped[0] < blen || popped[1] < blen) && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("done_beats1", popped[0], blen);
    chk("done_beats3", popped[1], blen);
    chk("done_reads1", issued[0], blen);
    chk("done_reads3", issued[1], blen);
    chk("done_ready", 32'(rr[0] && rr[1]), 1);
  endtask

  initial begin
    clear_model(0, 0);
    repeat (3) @(posedge clk);
    #1 chk_reset();
    rst = 1;
    @(posedge clk); #1;
    req(5, 1); wait_done();
    req(16, 4); wait_done();
    mode = 2;
    req(0, 8); wait_done();
    mode = 0;
    req(SIZE - 2, 4); wait_done();
    req(7, 0);
    chk("len0_busy", 32'(bz[0] || bz[1]), 0);
    chk("len0_ready", 32'(rr[0] && rr[1]), 1);
    repeat (6) @(posedge clk);
    #1 wait_done();
    req(0, 5); wait_done();
    mode = 1;
    for (int i = 0; i < 20; i++) begin
      req(int'($urandom_range(0, SIZE - 1)), int'($urandom_range(1, 24)));
      wait_done();
    end
    req(int'($urandom_range(0, SIZE - 1)), 256); wait_done();
    mode = 0;
    req(0, 8);
    for (int t = 0; t < 100 && popped[0] < 2; t++) begin
      @(posedge clk); #1;
    end
    chk("mid_burst_reached", 32'(popped[0]), 2);
    #2 rst = 0;
    #1 chk_reset();
    clear_model(0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    repeat (10) @(posedge clk);
    #1 req(2, 2); wait_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
